// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_ctrl_seq
// Brief   : Handshaked ALU-control decoder with programmable MUL/DIV hold time.
// Revision: 1.0
// ============================================================================
module alu_ctrl_seq #(
  parameter int INSTR_W = 32,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [1:0]         alu_op_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [3:0]         alu_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               illegal
);

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_MULTI = 2'd1;
  localparam logic [1:0] C_ST_DONE  = 2'd2;

  localparam logic [3:0] C_SEL_ADD = 4'b0000;
  localparam logic [3:0] C_SEL_SUB = 4'b0001;
  localparam logic [3:0] C_SEL_MUL = 4'b0010;
  localparam logic [3:0] C_SEL_DIV = 4'b0011;
  localparam logic [3:0] C_SEL_AND = 4'b0100;
  localparam logic [3:0] C_SEL_OR  = 4'b0101;
  localparam logic [3:0] C_SEL_NOR = 4'b0110;
  localparam logic [3:0] C_SEL_NOP = 4'b0111;
  localparam logic [3:0] C_SEL_SRL = 4'b1000;
  localparam logic [3:0] C_SEL_SLT = 4'b1001;
  localparam logic [3:0] C_SEL_XOR = 4'b1010;
  localparam logic [3:0] C_SEL_SLTI = 4'b1011;

  // Counter preload is LAT-1 so the MULTI state lasts exactly LAT cycles.
  localparam logic [CNT_W-1:0] C_MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] C_DIV_CNT = CNT_W'(DIV_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       alu_q, alu_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] w_funct;
  logic [5:0] w_opcode;
  logic [3:0] w_dec_sel;
  logic       w_dec_ill;
  logic       w_dec_mul;
  logic       w_dec_div;
  logic       w_accept;
  logic       w_unused;

  assign w_funct  = instr_in[5:0];
  assign w_opcode = instr_in[INSTR_W-1 -: 6];
  assign w_unused = ^instr_in[INSTR_W-7:6];

  always_comb begin
    w_dec_sel = C_SEL_ADD;
    w_dec_ill = 1'b0;
    w_dec_mul = 1'b0;
    w_dec_div = 1'b0;
    case (alu_op_in)
      2'b00: w_dec_sel = C_SEL_ADD;
      2'b01: w_dec_sel = C_SEL_SUB;
      2'b10: begin
        case (w_funct)
          6'b100000: w_dec_sel = C_SEL_ADD;
          6'b100010: w_dec_sel = C_SEL_SUB;
          6'b000010: begin
            w_dec_sel = C_SEL_MUL;
            w_dec_mul = 1'b1;
          end
          6'b011010: begin
            w_dec_sel = C_SEL_DIV;
            w_dec_div = 1'b1;
          end
          6'b100100: w_dec_sel = C_SEL_AND;
          6'b100101: w_dec_sel = C_SEL_OR;
          6'b100111: w_dec_sel = C_SEL_NOR;
          6'b000000: w_dec_sel = C_SEL_NOP;
          6'b000011: w_dec_sel = C_SEL_SRL;
          6'b101010: w_dec_sel = C_SEL_SLT;
          6'b100110: w_dec_sel = C_SEL_XOR;
          default:   w_dec_ill = 1'b1;
        endcase
      end
      default: begin
        case (w_opcode)
          6'b001010: w_dec_sel = C_SEL_SLTI;
          6'b001100: w_dec_sel = C_SEL_AND;
          6'b001101: w_dec_sel = C_SEL_OR;
          6'b001110: w_dec_sel = C_SEL_XOR;
          6'b001000: w_dec_sel = C_SEL_ADD;
          default:   w_dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  // A DONE result may hand over to a new request in the same cycle it is consumed.
  assign in_ready = rst_n & ((state_q == C_ST_IDLE) |
                             ((state_q == C_ST_DONE) & out_ready));
  assign w_accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    case (state_q)
      C_ST_MULTI: begin
        if (cnt_q == '0) begin
          state_d = C_ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      C_ST_DONE: begin
        if (out_ready) begin
          state_d = C_ST_IDLE;
        end
      end
      default: state_d = C_ST_IDLE;
    endcase
    if (w_accept) begin
      alu_d = w_dec_sel;
      ill_d = w_dec_ill;
      if (w_dec_mul) begin
        state_d = C_ST_MULTI;
        cnt_d   = C_MUL_CNT;
      end else if (w_dec_div) begin
        state_d = C_ST_MULTI;
        cnt_d   = C_DIV_CNT;
      end else begin
        state_d = C_ST_DONE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= C_ST_IDLE;
      alu_q   <= C_SEL_NOP;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_out   = alu_q;
  assign illegal   = ill_q;
  assign out_valid = (state_q == C_ST_DONE);
  assign busy      = (state_q == C_ST_MULTI);

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_ctrl_seq
// Brief   : Directed plus randomized checks of alu_ctrl_seq against a table model.
// Revision: 1.0
// ============================================================================
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_in;
  logic [1:0]  alu_op_in;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  logic [5:0] fc [11] = '{6'h20, 6'h22, 6'h02, 6'h1A, 6'h24, 6'h25,
                          6'h27, 6'h00, 6'h03, 6'h2A, 6'h26};
  logic [3:0] fs [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                          4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
  logic [5:0] oc [5]  = '{6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h08};
  logic [3:0] os [5]  = '{4'd11, 4'd4, 4'd5, 4'd10, 4'd0};

  alu_ctrl_seq #(
    .INSTR_W(32),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr_in (instr_in),
    .alu_op_in(alu_op_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_out  (alu_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected select, illegal flag and hold latency straight from the decode tables.
  task automatic model(input logic [1:0] mode, input logic [31:0] instr,
                       output logic [3:0] sel, output logic ill, output int lat);
    sel = 4'd0;
    ill = 1'b0;
    lat = 0;
    if (mode == 2'b01) begin
      sel = 4'd1;
    end else if (mode == 2'b10) begin
      ill = 1'b1;
      for (int i = 0; i < 11; i++)
        if (instr[5:0] == fc[i]) begin
          sel = fs[i];
          ill = 1'b0;
        end
      if (!ill && instr[5:0] == 6'h02) lat = MUL_LAT;
      if (!ill && instr[5:0] == 6'h1A) lat = DIV_LAT;
    end else if (mode == 2'b11) begin
      ill = 1'b1;
      for (int i = 0; i < 5; i++)
        if (instr[31:26] == oc[i]) begin
          sel = os[i];
          ill = 1'b0;
        end
    end
  endtask

  task automatic run_one(input logic [1:0] mode, input logic [31:0] instr,
                         input int stall, input string tag);
    logic [3:0] es;
    logic       ei;
    int         el;
    int         n;
    model(mode, instr, es, ei, el);
    alu_op_in = mode;
    instr_in  = instr;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    step();
    in_valid  = 1'b0;
    instr_in  = $urandom;
    alu_op_in = 2'($urandom_range(0, 3));
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      chk({tag, ".busy_wait"}, busy, 1);
      chk({tag, ".in_ready_wait"}, in_ready, 0);
      n++;
      step();
    end
    chk({tag, ".latency"}, n, el);
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".alu_out"}, alu_out, es);
    chk({tag, ".illegal"}, illegal, ei);
    chk({tag, ".busy_done"}, busy, 0);
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, ".stall_valid"}, out_valid, 1);
      chk({tag, ".stall_alu"}, alu_out, es);
      chk({tag, ".stall_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk({tag, ".valid_drop"}, out_valid, 0);
    chk({tag, ".alu_keep"}, alu_out, es);
    chk({tag, ".in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    logic [5:0]  bt_f [4];
    logic [3:0]  bt_s [4];
    logic [31:0] r;
    logic [1:0]  m;

    rst_n     = 1'b1;
    instr_in  = '0;
    alu_op_in = 2'b00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.alu_out", alu_out, 4'b0111);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.illegal", illegal, 0);
    rst_n = 1'b1;
    step();
    chk("idle.in_ready", in_ready, 1);
    chk("idle.alu_out", alu_out, 4'b0111);

    run_one(2'b10, 32'h0000_0020, 0, "add");
    run_one(2'b10, 32'h0000_0002, 0, "mul");
    run_one(2'b10, 32'h0000_001A, 0, "div");

    bt_f = '{6'h25, 6'h2A, 6'h26, 6'h27};
    bt_s = '{4'b0101, 4'b1001, 4'b1010, 4'b0110};
    out_ready = 1'b1;
    alu_op_in = 2'b10;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      instr_in = {r[31:6], bt_f[i]};
      step();
      chk("b2b.out_valid", out_valid, 1);
      chk("b2b.alu_out", alu_out, bt_s[i]);
    end
    in_valid = 1'b0;
    step();
    chk("b2b.drain", out_valid, 0);

    out_ready = 1'b0;
    alu_op_in = 2'b10;
    instr_in  = 32'h0000_0003;
    in_valid  = 1'b1;
    step();
    alu_op_in = 2'b00;
    instr_in  = 32'h0000_0020;
    for (int i = 0; i < 5; i++) begin
      chk("stall.out_valid", out_valid, 1);
      chk("stall.alu_out", alu_out, 4'b1000);
      chk("stall.in_ready", in_ready, 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("stall.release", out_valid, 0);
    chk("stall.not_captured", alu_out, 4'b1000);

    run_one(2'b11, 32'h2800_0000, 0, "slti");
    run_one(2'b11, 32'hFC00_0000, 1, "bad_opc");
    run_one(2'b10, 32'h0000_003F, 2, "bad_funct");
    run_one(2'b00, 32'h1234_5678, 0, "mode00");
    run_one(2'b01, 32'h1234_5678, 1, "mode01");

    alu_op_in = 2'b10;
    instr_in  = 32'h0000_001A;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("abort.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort.alu_out", alu_out, 4'b0111);
    chk("abort.busy", busy, 0);
    chk("abort.out_valid", out_valid, 0);
    chk("abort.in_ready", in_ready, 0);
    chk("abort.illegal", illegal, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort.no_result", {busy, out_valid}, 2'b00);
    end

    for (int k = 0; k < 40; k++) begin
      m = 2'($urandom_range(0, 3));
      r = $urandom;
      if ($urandom_range(0, 1) == 1) r[5:0] = fc[$urandom_range(0, 10)];
      if ($urandom_range(0, 1) == 1) r[31:26] = oc[$urandom_range(0, 4)];
      run_one(m, r, $urandom_range(0, 2), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
